// File: rtl/shared_counter_arbiter_if.sv
// Bus between the requesting controllers and the shared counter arbiter.
// Controllers drive requests, lengths and the event strobe; the arbiter
// returns grant, completion and the live count.
interface shared_counter_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req_i;
  logic [WIDTH-1:0] len0_i;
  logic [WIDTH-1:0] len1_i;
  logic             in_i;
  logic [1:0]       gnt_o;
  logic [1:0]       done_o;
  logic [WIDTH-1:0] count_o;

  modport master (
    output req_i, len0_i, len1_i, in_i,
    input  gnt_o, done_o, count_o
  );

  modport slave (
    input  req_i, len0_i, len1_i, in_i,
    output gnt_o, done_o, count_o
  );
endinterface

// File: rtl/shared_counter_arbiter.sv
// Two-channel round-robin arbiter sequencing one shared event counter.
// A granted channel has in_i strobes counted up to the length it supplied
// at grant time, then gets a one-cycle done pulse. Outputs decode the
// state register only (Moore).
module shared_counter_arbiter #(
  parameter int WIDTH = 4
) (
  input logic                     clk_i,
  input logic                     nreset_i,
  shared_counter_arbiter_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BUSY0 = 3'd1;
  localparam logic [2:0] BUSY1 = 3'd2;
  localparam logic [2:0] DONE0 = 3'd3;
  localparam logic [2:0] DONE1 = 3'd4;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] len_q_reg, len_q_next;
  logic             last_reg, last_next;

  logic             grant_ch;
  logic             busy_ch;
  logic [WIDTH-1:0] count_inc;
  logic [1:0]       gnt;
  logic [1:0]       done;

  // count + 1 never wraps in BUSY because count stays below len_q there
  assign count_inc = count_reg + ONE;

  // Arbitration, event counting, completion and abort decisions
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    len_q_next = len_q_reg;
    last_next  = last_reg;
    // Both requesting: serve the channel that was not served last
    grant_ch   = (bus.req_i == 2'b11) ? ~last_reg : bus.req_i[1];
    busy_ch    = (state_reg == BUSY1);

    case (state_reg)
      IDLE: begin
        if (|bus.req_i) begin
          state_next = grant_ch ? BUSY1 : BUSY0;
          count_next = '0;
          len_q_next = grant_ch ? bus.len1_i : bus.len0_i;
        end
      end
      BUSY0, BUSY1: begin
        if (!bus.req_i[busy_ch]) begin
          // Abort wins over a completing event; count is held, no done
          state_next = IDLE;
          last_next  = busy_ch;
        end else if (len_q_reg == '0) begin
          // Zero-length job completes on the next edge without events
          state_next = busy_ch ? DONE1 : DONE0;
          last_next  = busy_ch;
        end else if (bus.in_i) begin
          if (count_inc == len_q_reg) begin
            state_next = busy_ch ? DONE1 : DONE0;
            count_next = len_q_reg;
            last_next  = busy_ch;
          end else begin
            count_next = count_inc;
          end
        end
      end
      DONE0, DONE1: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_reg <= IDLE;
      count_reg <= '0;
      len_q_reg <= '0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      len_q_reg <= len_q_next;
      last_reg  <= last_next;
    end
  end

  // Per-channel grant/done decode of the state register
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    localparam logic [2:0] BUSY_ST = (gi == 0) ? BUSY0 : BUSY1;
    localparam logic [2:0] DONE_ST = (gi == 0) ? DONE0 : DONE1;
    assign gnt[gi]  = (state_reg == BUSY_ST);
    assign done[gi] = (state_reg == DONE_ST);
  end

  assign bus.gnt_o   = gnt;
  assign bus.done_o  = done;
  assign bus.count_o = count_reg;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Directed bench for shared_counter_arbiter: single grant, gapped events,
// contention/rotation, zero length, abort and asynchronous reset mid-job.
module tb_shared_counter_arbiter;

  logic clk_i;
  logic nreset_i;
  int   n_assert;
  int   n_fail;

  shared_counter_arbiter_if #(.WIDTH(4)) bus ();

  shared_counter_arbiter #(.WIDTH(4)) dut (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .bus      (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
      $display("check %-12s observed %0h expected %0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] g, input logic [1:0] d, input logic [3:0] c);
    check({tag, ".gnt"},   {6'd0, bus.gnt_o},   {6'd0, g});
    check({tag, ".done"},  {6'd0, bus.done_o},  {6'd0, d});
    check({tag, ".count"}, {4'd0, bus.count_o}, {4'd0, c});
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    nreset_i    = 1'b0;
    bus.req_i   = 2'b00;
    bus.len0_i  = 4'd0;
    bus.len1_i  = 4'd0;
    bus.in_i    = 1'b0;
    #2;
    chk("reset", 2'b00, 2'b00, 4'd0);
    step();
    nreset_i = 1'b1;

    // Single grant, len0=3, continuous events
    bus.req_i = 2'b01; bus.len0_i = 4'd3; bus.in_i = 1'b1;
    step(); chk("sg.b0", 2'b01, 2'b00, 4'd0);
    step(); chk("sg.b1", 2'b01, 2'b00, 4'd1);
    step(); chk("sg.b2", 2'b01, 2'b00, 4'd2);
    step(); chk("sg.done", 2'b00, 2'b01, 4'd3);
    bus.req_i = 2'b00;
    step(); chk("sg.idle", 2'b00, 2'b00, 4'd3);

    // Gapped events on channel 1, len1=2, pattern 1,0,0,1
    bus.req_i = 2'b10; bus.len1_i = 4'd2; bus.in_i = 1'b0;
    step(); chk("gap.b0", 2'b10, 2'b00, 4'd0);
    bus.in_i = 1'b1; step(); chk("gap.e1", 2'b10, 2'b00, 4'd1);
    bus.in_i = 1'b0; step(); chk("gap.e2", 2'b10, 2'b00, 4'd1);
    bus.in_i = 1'b0; step(); chk("gap.e3", 2'b10, 2'b00, 4'd1);
    bus.in_i = 1'b1; step(); chk("gap.done", 2'b00, 2'b10, 4'd2);
    bus.req_i = 2'b00;
    step(); chk("gap.idle1", 2'b00, 2'b00, 4'd2);
    step(); chk("gap.idle2", 2'b00, 2'b00, 4'd2);

    // Contention, len=1 each; last=1 so ch0 first, then ch1, then ch0
    bus.req_i = 2'b11; bus.len0_i = 4'd1; bus.len1_i = 4'd1; bus.in_i = 1'b1;
    step(); chk("rr.g0", 2'b01, 2'b00, 4'd0);
    step(); chk("rr.d0", 2'b00, 2'b01, 4'd1);
    step(); chk("rr.i0", 2'b00, 2'b00, 4'd1);
    step(); chk("rr.g1", 2'b10, 2'b00, 4'd0);
    step(); chk("rr.d1", 2'b00, 2'b10, 4'd1);
    step(); chk("rr.i1", 2'b00, 2'b00, 4'd1);
    step(); chk("rr.g0b", 2'b01, 2'b00, 4'd0);
    // Drop request on a completing edge: abort wins, no done pulse
    bus.req_i = 2'b00;
    step(); chk("rr.abort", 2'b00, 2'b00, 4'd0);

    // Zero length on channel 0
    bus.req_i = 2'b01; bus.len0_i = 4'd0; bus.in_i = 1'b0;
    step(); chk("z.b0", 2'b01, 2'b00, 4'd0);
    step(); chk("z.done", 2'b00, 2'b01, 4'd0);
    bus.req_i = 2'b00;
    step(); chk("z.idle", 2'b00, 2'b00, 4'd0);

    // Abort after 2 events, len0=5
    bus.req_i = 2'b01; bus.len0_i = 4'd5; bus.in_i = 1'b1;
    step(); chk("ab.b0", 2'b01, 2'b00, 4'd0);
    step(); chk("ab.e1", 2'b01, 2'b00, 4'd1);
    step(); chk("ab.e2", 2'b01, 2'b00, 4'd2);
    bus.req_i = 2'b00;
    step(); chk("ab.idle", 2'b00, 2'b00, 4'd2);
    step(); chk("ab.nodone", 2'b00, 2'b00, 4'd2);
    // last=0 now, so contention grants ch1
    bus.req_i = 2'b11; bus.len1_i = 4'd5;
    step(); chk("ab.g1", 2'b10, 2'b00, 4'd0);
    step(); chk("ab.c1", 2'b10, 2'b00, 4'd1);
    step(); chk("ab.c2", 2'b10, 2'b00, 4'd2);
    step(); chk("ab.c3", 2'b10, 2'b00, 4'd3);

    // Asynchronous reset pulse between edges while BUSY1 with count=3
    #2 nreset_i = 1'b0;
    #1 chk("ar.during", 2'b00, 2'b00, 4'd0);
    #1 nreset_i = 1'b1;
    // last=1 after reset, so ch0 wins the contention
    step(); chk("ar.g0", 2'b01, 2'b00, 4'd0);
    step(); chk("ar.c1", 2'b01, 2'b00, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
